// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle core: walks the shared datapath through
// IF/ID/EXE/MEM/WB one instruction at a time and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_ready,
  input  logic             data_ready,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             gr_we,
  input  logic             br_taken,
  output logic [2:0]       state,
  output logic             inst_req,
  output logic             ir_we,
  output logic             ab_we,
  output logic             alu_we,
  output logic             data_req,
  output logic             data_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             commit,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = S_IF;
    inst_req = 1'b0;
    ir_we    = 1'b0;
    ab_we    = 1'b0;
    alu_we   = 1'b0;
    data_req = 1'b0;
    data_we  = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    commit   = 1'b0;
    taken_d  = taken_q;
    unique case (state_q)
      S_IF: begin
        inst_req = 1'b1;
        ir_we    = inst_ready;
        state_d  = inst_ready ? S_ID : S_IF;
      end
      S_ID: begin
        ab_we   = 1'b1;
        state_d = S_EXE;
      end
      S_EXE: begin
        alu_we = 1'b1;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (gr_we) begin
          // jirl/bl redirect the PC only in WB, so the decision is held until then
          taken_d = br_taken;
          state_d = S_WB;
        end else begin
          pc_we   = 1'b1;
          pc_sel  = br_taken;
          commit  = 1'b1;
          state_d = S_IF;
        end
      end
      S_MEM: begin
        data_req = 1'b1;
        data_we  = is_store & ~is_load;
        if (!data_ready) begin
          state_d = S_MEM;
        end else if (is_load) begin
          mdr_we  = 1'b1;
          state_d = S_WB;
        end else begin
          pc_we   = 1'b1;
          commit  = 1'b1;
          state_d = S_IF;
        end
      end
      S_WB: begin
        rf_we   = gr_we;
        pc_we   = 1'b1;
        pc_sel  = taken_q;
        commit  = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase

    if (state_d == S_IF) taken_d = 1'b0;

    // A reset cycle aborts whatever instruction is in flight, including its retirement
    if (reset) begin
      inst_req = 1'b0;
      ir_we    = 1'b0;
      ab_we    = 1'b0;
      alu_we   = 1'b0;
      data_req = 1'b0;
      data_we  = 1'b0;
      mdr_we   = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      commit   = 1'b0;
    end

    cnt_d = commit ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state      = state_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and output vectors
// hand-derived from the instruction sequences, plus retire counter checks.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  // Expected output vector bit positions
  localparam logic [10:0] IREQ   = 11'h400;
  localparam logic [10:0] IRWE   = 11'h200;
  localparam logic [10:0] ABWE   = 11'h100;
  localparam logic [10:0] ALUWE  = 11'h080;
  localparam logic [10:0] DREQ   = 11'h040;
  localparam logic [10:0] DWE    = 11'h020;
  localparam logic [10:0] MDRWE  = 11'h010;
  localparam logic [10:0] RFWE   = 11'h008;
  localparam logic [10:0] PCWE   = 11'h004;
  localparam logic [10:0] PCSEL  = 11'h002;
  localparam logic [10:0] COMMIT = 11'h001;
  localparam logic [10:0] NONE   = 11'h000;

  logic             clk = 1'b0;
  logic             reset;
  logic             inst_ready, data_ready, is_load, is_store, gr_we, br_taken;
  logic [2:0]       state;
  logic             inst_req, ir_we, ab_we, alu_we, data_req, data_we, mdr_we;
  logic             rf_we, pc_we, pc_sel, commit;
  logic [CNT_W-1:0] retire_cnt;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_ready (inst_ready),
    .data_ready (data_ready),
    .is_load    (is_load),
    .is_store   (is_store),
    .gr_we      (gr_we),
    .br_taken   (br_taken),
    .state      (state),
    .inst_req   (inst_req),
    .ir_we      (ir_we),
    .ab_we      (ab_we),
    .alu_we     (alu_we),
    .data_req   (data_req),
    .data_we    (data_we),
    .mdr_we     (mdr_we),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .commit     (commit),
    .retire_cnt (retire_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {inst_req, ir_we, ab_we, alu_we, data_req, data_we,
            mdr_we, rf_we, pc_we, pc_sel, commit};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs (called just after a posedge), check at negedge,
  // then advance to just past the next posedge.
  task automatic cyc(input string tag, input logic ir, input logic dr,
                     input logic ld, input logic st, input logic gw, input logic bt,
                     input logic [2:0] exp_state, input logic [10:0] exp_out);
    inst_ready = ir;
    data_ready = dr;
    is_load    = ld;
    is_store   = st;
    gr_we      = gw;
    br_taken   = bt;
    @(negedge clk);
    check({tag, "_state"}, 32'(state), 32'(exp_state));
    check({tag, "_outs"},  32'(outs()), 32'(exp_out));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst_ready = 0; data_ready = 0; is_load = 0; is_store = 0; gr_we = 0; br_taken = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs",  32'(outs()), 32'd0);
    check("rst_cnt",   32'(retire_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // add.w, zero wait; data_ready high outside MEM must be ignored
    cyc("add_if",  1, 1, 0, 0, 1, 0, 3'd0, IREQ | IRWE);
    cyc("add_id",  0, 1, 0, 0, 1, 0, 3'd1, ABWE);
    cyc("add_exe", 0, 1, 0, 0, 1, 0, 3'd2, ALUWE);
    cyc("add_wb",  0, 0, 0, 0, 1, 0, 3'd4, RFWE | PCWE | COMMIT);
    check("add_cnt", 32'(retire_cnt), 32'd1);

    // beq taken
    cyc("beq_if",  1, 0, 0, 0, 0, 1, 3'd0, IREQ | IRWE);
    cyc("beq_id",  1, 0, 0, 0, 0, 1, 3'd1, ABWE);
    cyc("beq_exe", 0, 0, 0, 0, 0, 1, 3'd2, ALUWE | PCWE | PCSEL | COMMIT);
    check("beq_cnt", 32'(retire_cnt), 32'd2);

    // ld.w with two data wait cycles
    cyc("ld_if",   1, 0, 1, 0, 1, 0, 3'd0, IREQ | IRWE);
    cyc("ld_id",   0, 0, 1, 0, 1, 0, 3'd1, ABWE);
    cyc("ld_exe",  0, 0, 1, 0, 1, 0, 3'd2, ALUWE);
    cyc("ld_mem0", 0, 0, 1, 0, 1, 0, 3'd3, DREQ);
    cyc("ld_mem1", 0, 0, 1, 0, 1, 0, 3'd3, DREQ);
    cyc("ld_mem2", 0, 1, 1, 0, 1, 0, 3'd3, DREQ | MDRWE);
    cyc("ld_wb",   0, 0, 1, 0, 1, 0, 3'd4, RFWE | PCWE | COMMIT);
    check("ld_cnt", 32'(retire_cnt), 32'd3);

    // st.w with three fetch wait cycles
    cyc("st_if0",  0, 1, 0, 1, 0, 0, 3'd0, IREQ);
    cyc("st_if1",  0, 0, 0, 1, 0, 0, 3'd0, IREQ);
    cyc("st_if2",  0, 0, 0, 1, 0, 0, 3'd0, IREQ);
    cyc("st_if3",  1, 0, 0, 1, 0, 0, 3'd0, IREQ | IRWE);
    cyc("st_id",   0, 0, 0, 1, 0, 0, 3'd1, ABWE);
    cyc("st_exe",  0, 0, 0, 1, 0, 0, 3'd2, ALUWE);
    cyc("st_mem",  0, 1, 0, 1, 0, 0, 3'd3, DREQ | DWE | PCWE | COMMIT);
    check("st_cnt", 32'(retire_cnt), 32'd4);

    // bl taken: flag captured in EXE, used in WB even though br_taken has dropped
    cyc("bl_if",   1, 0, 0, 0, 1, 1, 3'd0, IREQ | IRWE);
    cyc("bl_id",   0, 0, 0, 0, 1, 1, 3'd1, ABWE);
    cyc("bl_exe",  0, 0, 0, 0, 1, 1, 3'd2, ALUWE);
    cyc("bl_wb",   0, 0, 0, 0, 1, 0, 3'd4, RFWE | PCWE | PCSEL | COMMIT);
    // following add.w must see the flag cleared
    cyc("add2_if",  1, 0, 0, 0, 1, 0, 3'd0, IREQ | IRWE);
    cyc("add2_id",  0, 0, 0, 0, 1, 0, 3'd1, ABWE);
    cyc("add2_exe", 0, 0, 0, 0, 1, 0, 3'd2, ALUWE);
    cyc("add2_wb",  0, 0, 0, 0, 1, 1, 3'd4, RFWE | PCWE | COMMIT);
    check("add2_cnt", 32'(retire_cnt), 32'd6);

    // load and store both set: load wins, no write strobe
    cyc("ls_if",   1, 0, 1, 1, 1, 0, 3'd0, IREQ | IRWE);
    cyc("ls_id",   0, 0, 1, 1, 1, 0, 3'd1, ABWE);
    cyc("ls_exe",  0, 0, 1, 1, 1, 0, 3'd2, ALUWE);
    cyc("ls_mem",  0, 1, 1, 1, 1, 0, 3'd3, DREQ | MDRWE);
    cyc("ls_wb",   0, 0, 1, 1, 1, 0, 3'd4, RFWE | PCWE | COMMIT);
    check("ls_cnt", 32'(retire_cnt), 32'd7);

    // reset while a load sits in MEM
    cyc("rl_if",   1, 0, 1, 0, 1, 0, 3'd0, IREQ | IRWE);
    cyc("rl_id",   0, 0, 1, 0, 1, 0, 3'd1, ABWE);
    cyc("rl_exe",  0, 0, 1, 0, 1, 0, 3'd2, ALUWE);
    cyc("rl_mem",  0, 0, 1, 0, 1, 0, 3'd3, DREQ);
    reset = 1'b1;
    data_ready = 1'b1;
    @(negedge clk);
    check("rl_rst_state", 32'(state), 32'd3);
    check("rl_rst_outs",  32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rl_cnt", 32'(retire_cnt), 32'd0);
    cyc("rl_after", 0, 1, 1, 0, 1, 0, 3'd0, IREQ);

    // 16 branch-class commits wrap a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      cyc("wrap_if",  1, 0, 0, 0, 0, 0, 3'd0, IREQ | IRWE);
      cyc("wrap_id",  0, 0, 0, 0, 0, 0, 3'd1, ABWE);
      cyc("wrap_exe", 0, 0, 0, 0, 0, 0, 3'd2, ALUWE | PCWE | COMMIT);
      if (i == 14) check("wrap_cnt15", 32'(retire_cnt), 32'd15);
    end
    check("wrap_cnt0", 32'(retire_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
